onewire_decoder: RTL and testbench

ONEWIRE_DECODER -- requirements
Module: onewire_decoder

---
 rtl/onewire_decoder_if.sv | 11 +
 rtl/onewire_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_onewire_decoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/onewire_decoder_if.sv
// Read-side handshake between the one-wire decoder's byte FIFO and its consumer.
// The decoder drives the data and status signals. The consumer drives rd_ready.
interface onewire_decoder_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] fifo_count;

  modport master (output rd_data, output rd_valid, output fifo_count, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input fifo_count, output rd_ready);
endinterface

// File: rtl/onewire_decoder.sv
// Pulse-width one-wire line decoder: classifies low pulses into bits, assembles bytes MSB first,
// and queues them in a 4-entry FIFO, reporting framing and overflow errors with a sticky code.
module onewire_decoder #(
  parameter int unsigned ONE_MAX_LOW  = 10,
  parameter int unsigned ZERO_MIN_LOW = 12,
  parameter int unsigned ZERO_MAX_LOW = 24,
  parameter int unsigned GLITCH_LOW   = 2,
  parameter int unsigned STOP_HIGH    = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sg_in,
  input  logic                     err_clr,
  onewire_decoder_if.master        rd,
  output logic                     in_frame,
  output logic                     frame_end,
  output logic [1:0]               err
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BITCNT_W  = 3;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned COUNT_W   = 3;

  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]    ONE_MAX_C  = CNT_W'(ONE_MAX_LOW);
  localparam logic [CNT_W-1:0]    ZERO_MIN_C = CNT_W'(ZERO_MIN_LOW);
  localparam logic [CNT_W-1:0]    ZERO_MAX_C = CNT_W'(ZERO_MAX_LOW);
  localparam logic [CNT_W-1:0]    GLITCH_C   = CNT_W'(GLITCH_LOW);
  localparam logic [CNT_W-1:0]    STOP_C     = CNT_W'(STOP_HIGH);
  localparam logic [COUNT_W-1:0]  FULL_C     = COUNT_W'(DEPTH);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_PULSE = 2'b01;
  localparam logic [1:0] ERR_PART  = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  typedef enum logic [2:0] {ST_ARM, ST_IDLE, ST_LOW, ST_HIGH, ST_ERR} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  s_prev_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BYTE_W-1:0]     sr_q, sr_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic                  push_q, push_d;
  logic                  in_frame_q, in_frame_d;
  logic                  frame_end_q, frame_end_d;
  logic [1:0]            err_q, err_d;
  logic                  err_pulse_c, err_part_c;
  logic                  bit_valid_c, bit_val_c;

  logic [BYTE_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc_c;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [BYTE_W-1:0]     rd_data_q, rd_data_d;
  logic                  rd_valid_q;
  logic                  pop_c, wr_en_c, ovf_c;

  logic s_c, fall_c, rise_c;

  assign s_c    = sync_q[1];
  assign fall_c = s_prev_q & ~s_c;
  assign rise_c = ~s_prev_q & s_c;

  // Synchronizer, edge history and width counter (counter holds width of the level just ended at an edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      s_prev_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], sg_in};
      s_prev_q <= s_c;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fall_c || rise_c)    cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // FSM state and decode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARM;
      sr_q        <= '0;
      bitcnt_q    <= '0;
      push_q      <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bitcnt_q    <= bitcnt_d;
      push_q      <= push_d;
      in_frame_q  <= in_frame_d;
      frame_end_q <= frame_end_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bitcnt_d    = bitcnt_q;
    push_d      = 1'b0;
    in_frame_d  = in_frame_q;
    frame_end_d = 1'b0;
    err_pulse_c = 1'b0;
    err_part_c  = 1'b0;
    bit_valid_c = 1'b0;
    bit_val_c   = 1'b0;

    case (state_q)
      ST_ARM, ST_ERR: begin
        sr_d       = '0;
        bitcnt_d   = '0;
        in_frame_d = 1'b0;
        if (s_c && !rise_c && cnt_q >= STOP_C) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (fall_c) begin
          state_d    = ST_LOW;
          in_frame_d = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise_c) begin
          state_d = ST_HIGH;
          if (cnt_q <= GLITCH_C) begin
            bit_valid_c = 1'b0;
          end else if (cnt_q <= ONE_MAX_C) begin
            bit_valid_c = 1'b1;
            bit_val_c   = 1'b1;
          end else if (cnt_q >= ZERO_MIN_C && cnt_q <= ZERO_MAX_C) begin
            bit_valid_c = 1'b1;
          end else begin
            err_pulse_c = 1'b1;
          end
        end else if (cnt_q > ZERO_MAX_C) begin
          err_pulse_c = 1'b1;
        end
      end
      ST_HIGH: begin
        if (fall_c) begin
          state_d = ST_LOW;
        end else if (cnt_q >= STOP_C) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          in_frame_d  = 1'b0;
          err_part_c  = (bitcnt_q != '0);
          sr_d        = '0;
          bitcnt_d    = '0;
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (err_pulse_c) begin
      state_d    = ST_ERR;
      in_frame_d = 1'b0;
      sr_d       = '0;
      bitcnt_d   = '0;
    end

    // Completed byte stays in sr_q for one cycle while the FIFO takes it
    if (bit_valid_c) begin
      sr_d     = {sr_q[BYTE_W-2:0], bit_val_c};
      bitcnt_d = bitcnt_q + BITCNT_W'(1);
      push_d   = (bitcnt_q == BITCNT_W'(7));
    end
  end

  // FIFO control; count kept separately so full and empty are unambiguous
  assign pop_c        = rd_valid_q & rd.rd_ready;
  assign wr_en_c      = push_q & ((count_q != FULL_C) | pop_c);
  assign ovf_c        = push_q & (count_q == FULL_C) & ~pop_c;
  assign rd_ptr_inc_c = rd_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d  = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c ? rd_ptr_inc_c : rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_en_c && !pop_c)      count_d = count_q + COUNT_W'(1);
    else if (!wr_en_c && pop_c) count_d = count_q - COUNT_W'(1);

    if (pop_c) begin
      if (count_q > COUNT_W'(1)) rd_data_d = mem_q[rd_ptr_inc_c];
      else if (wr_en_c)          rd_data_d = sr_q;
    end else if (count_q == '0 && wr_en_c) begin
      rd_data_d = sr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en_c) mem_q[wr_ptr_q] <= sr_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= (count_d != '0);
    end
  end

  // Sticky error: a new error beats a clear in the same cycle
  always_comb begin
    err_d = err_q;
    if (ovf_c)            err_d = ERR_OVF;
    else if (err_part_c)  err_d = ERR_PART;
    else if (err_pulse_c) err_d = ERR_PULSE;
    else if (err_clr)     err_d = ERR_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= ERR_NONE;
    else        err_q <= err_d;
  end

  assign rd.rd_data    = rd_data_q;
  assign rd.rd_valid   = rd_valid_q;
  assign rd.fifo_count = count_q;
  assign in_frame      = in_frame_q;
  assign frame_end     = frame_end_q;
  assign err           = err_q;

endmodule

// File: tb/tb_onewire_decoder.sv
// Directed bench for onewire_decoder: drives timed low/high pulses on the line and checks decoded
// bytes, FIFO behaviour, error codes and reset with immediate assertions.
module tb_onewire_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sg_in;
  logic       err_clr;
  logic       in_frame;
  logic       frame_end;
  logic [1:0] err;

  int n_pass  = 0;
  int n_total = 0;
  int fe_cnt  = 0;
  int fe_base;

  onewire_decoder_if rd_if ();

  onewire_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sg_in     (sg_in),
    .err_clr   (err_clr),
    .rd        (rd_if),
    .in_frame  (in_frame),
    .frame_end (frame_end),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_end === 1'b1) fe_cnt <= fe_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int n);
    sg_in = v;
    tick(n);
  endtask

  task automatic send_bit(input logic b);
    line(1'b0, b ? 6 : 17);
    line(1'b1, 15);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pop_one();
    rd_if.rd_ready = 1'b1;
    tick(1);
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd_valid"},  32'(rd_if.rd_valid),   32'd0);
    check({pfx, "_rd_data"},   32'(rd_if.rd_data),    32'd0);
    check({pfx, "_count"},     32'(rd_if.fifo_count), 32'd0);
    check({pfx, "_in_frame"},  32'(in_frame),         32'd0);
    check({pfx, "_frame_end"}, 32'(frame_end),        32'd0);
    check({pfx, "_err"},       32'(err),              32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    sg_in          = 1'b1;
    err_clr        = 1'b0;
    rd_if.rd_ready = 1'b0;
    tick(3);
    check_reset_outputs("rst");

    // Single byte 0xA5
    rst_n = 1'b1;
    line(1'b1, 50);
    send_byte(8'hA5);
    line(1'b1, 40);
    check("a5_data",     32'(rd_if.rd_data),    32'hA5);
    check("a5_valid",    32'(rd_if.rd_valid),   32'd1);
    check("a5_count",    32'(rd_if.fifo_count), 32'd1);
    check("a5_err",      32'(err),              32'd0);
    check("a5_fe_count", 32'(fe_cnt),           32'd1);
    check("a5_in_frame", 32'(in_frame),         32'd0);
    pop_one();
    check("a5_pop_count", 32'(rd_if.fifo_count), 32'd0);
    check("a5_pop_valid", 32'(rd_if.rd_valid),   32'd0);

    // Two bytes, popped on consecutive cycles
    send_byte(8'h3C);
    send_byte(8'h81);
    line(1'b1, 40);
    check("two_count2", 32'(rd_if.fifo_count), 32'd2);
    check("two_head0",  32'(rd_if.rd_data),    32'h3C);
    tick(2);
    check("two_stable", 32'(rd_if.rd_data),    32'h3C);
    rd_if.rd_ready = 1'b1;
    tick(1);
    check("two_head1",  32'(rd_if.rd_data),    32'h81);
    check("two_count1", 32'(rd_if.fifo_count), 32'd1);
    tick(1);
    check("two_count0", 32'(rd_if.fifo_count), 32'd0);
    check("two_valid0", 32'(rd_if.rd_valid),   32'd0);
    rd_if.rd_ready = 1'b0;
    check("two_fe_count", 32'(fe_cnt), 32'd2);

    // Five bytes into a 4-deep FIFO: last one dropped, overflow flagged
    for (int i = 1; i <= 5; i++) send_byte(8'(8'h11 * i));
    line(1'b1, 40);
    check("ovf_count", 32'(rd_if.fifo_count), 32'd4);
    check("ovf_err",   32'(err),              32'd3);
    rd_if.rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_head%0d", i), 32'(rd_if.rd_data), 32'(8'h11 * i));
      tick(1);
    end
    rd_if.rd_ready = 1'b0;
    check("ovf_drained", 32'(rd_if.fifo_count), 32'd0);
    clear_err();
    check("ovf_err_clr", 32'(err), 32'd0);

    // 11-cycle low lands between the bit windows
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("bad_in_frame_mid", 32'(in_frame), 32'd1);
    line(1'b0, 11);
    line(1'b1, 5);
    check("bad_err",      32'(err),              32'd1);
    check("bad_in_frame", 32'(in_frame),         32'd0);
    check("bad_count",    32'(rd_if.fifo_count), 32'd0);
    clear_err();
    check("bad_err_clr", 32'(err), 32'd0);
    line(1'b1, 50);
    send_byte(8'h55);
    line(1'b1, 40);
    check("rec_data",  32'(rd_if.rd_data),    32'h55);
    check("rec_count", 32'(rd_if.fifo_count), 32'd1);
    check("rec_err",   32'(err),              32'd0);
    pop_one();

    // Partial frame of 5 bits
    fe_base = fe_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    line(1'b1, 40);
    check("part_fe",       32'(fe_cnt - fe_base),  32'd1);
    check("part_err",      32'(err),               32'd2);
    check("part_count",    32'(rd_if.fifo_count),  32'd0);
    check("part_in_frame", 32'(in_frame),          32'd0);
    clear_err();
    check("part_err_clr", 32'(err), 32'd0);

    // 0x96 with a 2-cycle low glitch in the middle of the byte
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    line(1'b0, 2);
    line(1'b1, 15);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    line(1'b1, 40);
    check("glitch_data",  32'(rd_if.rd_data),    32'h96);
    check("glitch_count", 32'(rd_if.fifo_count), 32'd1);
    check("glitch_err",   32'(err),              32'd0);
    pop_one();

    // Reset during bit 4 with two bytes queued
    send_byte(8'h11);
    send_byte(8'h22);
    line(1'b1, 40);
    check("mid_count", 32'(rd_if.fifo_count), 32'd2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    sg_in = 1'b0;
    tick(8);
    check("mid_in_frame", 32'(in_frame), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    tick(2);
    rst_n = 1'b1;
    line(1'b1, 50);
    check("post_rst_count", 32'(rd_if.fifo_count), 32'd0);
    send_byte(8'hC3);
    line(1'b1, 40);
    check("post_rst_data",     32'(rd_if.rd_data),    32'hC3);
    check("post_rst_count1",   32'(rd_if.fifo_count), 32'd1);
    check("post_rst_err",      32'(err),              32'd0);
    check("post_rst_in_frame", 32'(in_frame),         32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
